// File: rtl/cq_pkg.sv
// cq_pkg: shared constants, IDLE/HOLD encoding and pointer arithmetic for the circular queue.
package cq_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int WIDTH_DEF = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Distance from b to a for pointers pw bits wide (wrap bit included).
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b, input int pw);
        return (a - b) & ((32'd1 << pw) - 32'd1);
    endfunction

endpackage

// File: rtl/cq_rd_stage.sv
// cq_rd_stage: registered output entry of the queue read port (IDLE/HOLD).
module cq_rd_stage
    import cq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic [0:0] st;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            st   <= ST_IDLE;
            data <= '0;
        end else if (load) begin
            st   <= ST_HOLD;
            data <= din;
        end else if (clear) begin
            st <= ST_IDLE;
        end
    end

    assign valid = (st == ST_HOLD);

endmodule

// File: rtl/cq_read_port.sv
// cq_read_port: read side of a circular queue with a registered output entry.
// Define CQ_READ_PORT_COUNT_EN to add the registered occupancy output count.
module cq_read_port
    import cq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic [AW:0]      wr_ptr,
    input  logic             flush,
    output logic [AW-1:0]    mem_raddr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
`ifdef CQ_READ_PORT_COUNT_EN
    output logic [AW+1:0]    count,
`endif
    output logic [AW:0]      rd_ptr,
    output logic             empty
);

    localparam logic [AW:0] ONE = 1;

    logic        fetch;
    logic        xfer;
    logic [AW:0] rd_ptr_nxt;

    assign empty      = (rd_ptr == wr_ptr);
    assign fetch      = (!rd_valid || rd_ready) && !empty && !flush;
    assign xfer       = rd_valid && rd_ready;
    assign rd_ptr_nxt = flush ? wr_ptr : fetch ? rd_ptr + ONE : rd_ptr;
    assign mem_raddr  = rd_ptr[AW-1:0];

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            rd_ptr <= '0;
        else
            rd_ptr <= rd_ptr_nxt;
    end

    cq_rd_stage #(.WIDTH(WIDTH)) u_stage (
        .clk    (clk),
        .reset_ (reset_),
        .load   (fetch),
        .clear  (flush || (xfer && !fetch)),
        .din    (mem_rdata),
        .valid  (rd_valid),
        .data   (rd_data)
    );

`ifdef CQ_READ_PORT_COUNT_EN
    logic valid_nxt;

    // Built from next-state values so count tracks rd_ptr/rd_valid in the same cycle.
    assign valid_nxt = flush ? 1'b0 : fetch ? 1'b1 : xfer ? 1'b0 : rd_valid;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            count <= '0;
        else
            count <= (AW+2)'(ptr_diff(32'(wr_ptr), 32'(rd_ptr_nxt), AW + 1)) + (AW+2)'(valid_nxt);
    end
`endif

endmodule
